core_bus_responder: RTL and testbench

Memory-and-I/O responder for the ForthCPU core bus. Serves the core's word/byte reads and byte-lane writes from an internal word-organised RAM, and exposes a small I/O page holding an 8-deep transmit FIFO, an 8-deep receive FIFO and a status register. It sits directly on the core's `ADDR_BUF` / `DOUT_BUF` / `DIN_BUF` / `WR0_BUF` / `WR1_BUF` / `RD_BUF` pins and is the slave end of that interface.

---
 rtl/core_bus_responder.sv | 169 ++++++++++++++++
 tb/tb_core_bus_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_responder.sv
// Core-bus slave: word RAM plus an I/O page with TX/RX byte FIFOs and a status register.
// Latency: reads return on DIN_BUF one edge after RD_BUF; writes land on the sampling edge.
// Backpressure: no bus wait states; TX drains on TX_VALID&&TX_READY, RX fills on RX_VALID&&RX_READY.

// Small FIFO; the caller decides when a push is legal, including push-while-full-with-pop.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     core_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;

    assign head_dat = mem[rp];

    // Storage has no reset; only pointers and count define what is live.
    always_ff @(posedge core_clk) begin
        if (push) mem[wp] <= push_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PTR_ONE;
            if (pop)  rp <= rp + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end
endmodule

module core_bus_responder #(
    parameter int          AW         = 12,
    parameter logic [7:0]  IO_PAGE    = 8'hFF,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] ADDR_BUF,
    input  logic [15:0] DOUT_BUF,
    input  logic        WR0_BUF,
    input  logic        WR1_BUF,
    input  logic        RD_BUF,
    output logic [15:0] DIN_BUF,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic          io;
    logic [7:0]    io_off;
    logic [AW-1:0] ram_idx;
    logic [15:0]   ram [2**AW];

    logic [7:0]    tx_head;
    logic [7:0]    rx_head;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] rx_cnt;
    logic          tx_push_req, tx_push, tx_pop, tx_full;
    logic          rx_pop_req, rx_pop, rx_push;
    logic          status_rd, ovf, ovf_set;
    logic [31:0]   tx_cnt32, rx_cnt32;
    logic [3:0]    tx_disp, rx_disp;
    logic [15:0]   status;
    logic [15:0]   rd_word;

    assign io      = (ADDR_BUF[15:8] == IO_PAGE);
    assign io_off  = ADDR_BUF[7:0];
    assign ram_idx = ADDR_BUF[AW:1];

    // TX side: a push into a full FIFO still succeeds when the head leaves on the same edge.
    assign TX_VALID    = (tx_cnt != '0);
    assign TX_DATA     = TX_VALID ? tx_head : 8'h00;
    assign tx_full     = (tx_cnt == FULL_CNT);
    assign tx_pop      = TX_VALID && TX_READY;
    assign tx_push_req = WR0_BUF && io && (io_off == 8'h00);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);

    // RX side: the producer is held off while full, so RX pushes are never dropped.
    assign RX_READY   = (rx_cnt != FULL_CNT);
    assign rx_push    = RX_VALID && RX_READY;
    assign rx_pop_req = RD_BUF && io && (io_off == 8'h04);
    assign rx_pop     = rx_pop_req && (rx_cnt != '0);

    assign status_rd = RD_BUF && io && (io_off == 8'h02);
    assign ovf_set   = (tx_push_req && !tx_push) || (rx_pop_req && !rx_pop);

    // Counts shown in STATUS are clamped to fit their 4-bit fields.
    assign tx_cnt32 = 32'(tx_cnt);
    assign rx_cnt32 = 32'(rx_cnt);
    assign tx_disp  = (tx_cnt32 > 32'd15) ? 4'hF : tx_cnt32[3:0];
    assign rx_disp  = (rx_cnt32 > 32'd15) ? 4'hF : rx_cnt32[3:0];
    assign status   = {rx_disp, tx_disp, 3'b000, ovf,
                       (rx_cnt == '0), (rx_cnt == FULL_CNT),
                       (tx_cnt == '0), tx_full};

    fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .core_clk (CLK),
        .rst      (RESET),
        .push     (tx_push),
        .push_dat (DOUT_BUF[7:0]),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .count    (tx_cnt)
    );

    fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .core_clk (CLK),
        .rst      (RESET),
        .push     (rx_push),
        .push_dat (RX_DATA),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .count    (rx_cnt)
    );

    // Read mux; all values come from pre-edge state, so a same-edge write is not seen.
    always_comb begin
        rd_word = 16'h0000;
        if (io) begin
            case (io_off)
                8'h02:   rd_word = status;
                8'h04:   rd_word = (rx_cnt != '0) ? {8'h00, rx_head} : 16'h0000;
                default: rd_word = 16'h0000;
            endcase
        end else begin
            rd_word = ram[ram_idx];
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge CLK) begin
        if (!io && WR0_BUF) ram[ram_idx][7:0]  <= DOUT_BUF[7:0];
        if (!io && WR1_BUF) ram[ram_idx][15:8] <= DOUT_BUF[15:8];
    end

    // Read data register holds until the next read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)       DIN_BUF <= 16'h0000;
        else if (RD_BUF) DIN_BUF <= rd_word;
    end

    // Sticky overflow flag; a STATUS read returns it and then clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) ovf <= 1'b0;
        else       ovf <= (ovf && !status_rd) || ovf_set;
    end
endmodule

// File: tb/tb_core_bus_responder.sv
// Self-checking bench for core_bus_responder: directed scenarios then randomized traffic.
// Latency: each bus cycle is checked one edge after its inputs are applied.
// Backpressure: TX_READY / RX_VALID are driven from directed values or random bias.
module tb_core_bus_responder;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] ADDR_BUF, DOUT_BUF, DIN_BUF;
    logic        WR0_BUF, WR1_BUF, RD_BUF;
    logic [7:0]  TX_DATA, RX_DATA;
    logic        TX_VALID, TX_READY, RX_VALID, RX_READY;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [7:0]  tx_q[$];
    bit [7:0]  rx_q[$];
    bit        m_ovf;
    bit [15:0] m_mem [4096];
    bit        m_known [4096];
    bit [15:0] din_exp;
    bit        din_known;

    core_bus_responder dut (
        .CLK(CLK), .RESET(RESET), .ADDR_BUF(ADDR_BUF), .DOUT_BUF(DOUT_BUF),
        .WR0_BUF(WR0_BUF), .WR1_BUF(WR1_BUF), .RD_BUF(RD_BUF), .DIN_BUF(DIN_BUF),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit [15:0] model_status();
        int tc, rc;
        tc = tx_q.size();
        rc = rx_q.size();
        return {4'((rc > 15) ? 15 : rc), 4'((tc > 15) ? 15 : tc), 3'b000, m_ovf,
                rc == 0, rc == 8, tc == 0, tc == 8};
    endfunction

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_ovf     = 1'b0;
        din_exp   = 16'h0000;
        din_known = 1'b1;
    endtask

    // Predict the effect of the current inputs, clock one edge, then compare.
    task automatic cycle();
        bit        io, tx_pop, rx_push, ovf_set, st_rd, rd_known;
        bit [7:0]  off;
        int        widx;
        bit [15:0] rd_val, st;
        io      = (ADDR_BUF[15:8] == 8'hFF);
        off     = ADDR_BUF[7:0];
        widx    = int'(ADDR_BUF[12:1]);
        st      = model_status();
        tx_pop  = (tx_q.size() != 0) && TX_READY;
        rx_push = RX_VALID && (rx_q.size() < 8);
        st_rd   = RD_BUF && io && (off == 8'h02);
        ovf_set = 1'b0;
        rd_val  = 16'h0000;
        rd_known = 1'b1;
        if (RD_BUF) begin
            if (io) begin
                if (off == 8'h02) rd_val = st;
                else if (off == 8'h04 && rx_q.size() != 0) rd_val = {8'h00, rx_q[0]};
            end else begin
                rd_val   = m_mem[widx];
                rd_known = m_known[widx];
            end
        end
        if (RD_BUF && io && off == 8'h04) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else ovf_set = 1'b1;
        end
        if (rx_push) rx_q.push_back(RX_DATA);
        if (tx_pop) void'(tx_q.pop_front());
        if (WR0_BUF && io && off == 8'h00) begin
            if (tx_q.size() < 8) tx_q.push_back(DOUT_BUF[7:0]);
            else ovf_set = 1'b1;
        end
        if (!io && (WR0_BUF || WR1_BUF)) begin
            if (WR0_BUF) m_mem[widx][7:0]  = DOUT_BUF[7:0];
            if (WR1_BUF) m_mem[widx][15:8] = DOUT_BUF[15:8];
            m_known[widx] = m_known[widx] || (WR0_BUF && WR1_BUF);
        end
        m_ovf = (m_ovf && !st_rd) || ovf_set;
        if (RD_BUF) begin
            din_exp   = rd_val;
            din_known = rd_known;
        end
        @(posedge CLK);
        #1;
        if (din_known) check_eq("din", DIN_BUF, din_exp);
        check_eq("tx_valid", TX_VALID, tx_q.size() != 0);
        if (tx_q.size() != 0) check_eq("tx_data", TX_DATA, tx_q[0]);
        check_eq("rx_ready", RX_READY, rx_q.size() < 8);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input logic w0, input logic w1);
        ADDR_BUF = a; DOUT_BUF = d; WR0_BUF = w0; WR1_BUF = w1; RD_BUF = 1'b0;
        cycle();
        WR0_BUF = 1'b0; WR1_BUF = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a);
        ADDR_BUF = a; RD_BUF = 1'b1; WR0_BUF = 1'b0; WR1_BUF = 1'b0;
        cycle();
        RD_BUF = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; ADDR_BUF = '0; DOUT_BUF = '0; WR0_BUF = 0; WR1_BUF = 0; RD_BUF = 0;
        TX_READY = 0; RX_DATA = '0; RX_VALID = 0;
        model_reset();
        @(posedge CLK); #1;
        check_eq("rst_din", DIN_BUF, 16'h0000);
        check_eq("rst_tx_data", TX_DATA, 8'h00);
        check_eq("rst_tx_valid", TX_VALID, 1'b0);
        check_eq("rst_rx_ready", RX_READY, 1'b1);
        RESET = 1'b0;

        // Full-word write, read back, and alias through upper address bits.
        bus_wr(16'h1000, 16'h3579, 1, 1);
        bus_rd(16'h1000);
        check_eq("ram_word", DIN_BUF, 16'h3579);
        bus_rd(16'h3000);
        check_eq("ram_alias", DIN_BUF, 16'h3579);

        // Independent byte lanes.
        bus_wr(16'h1000, 16'h0000, 1, 1);
        bus_wr(16'h1000, 16'h35AA, 0, 1);
        bus_wr(16'h1001, 16'hBB35, 1, 0);
        bus_rd(16'h1000);
        check_eq("ram_lanes", DIN_BUF, 16'h3535);

        // TX fill past full: ninth push dropped, ovf set, then drain in order.
        TX_READY = 0;
        for (int i = 1; i <= 9; i++) bus_wr(16'hFF00, 16'(i), 1, 0);
        bus_wr(16'hFF00, 16'h0077, 0, 1);
        bus_rd(16'hFF02);
        check_eq("tx_status_full", DIN_BUF, 16'h0819);
        check_eq("tx_head", TX_DATA, 8'h01);
        TX_READY = 1;
        for (int i = 1; i <= 8; i++) begin
            check_eq("tx_order", TX_DATA, 8'(i));
            cycle();
        end
        TX_READY = 0;
        check_eq("tx_drained", TX_VALID, 1'b0);
        bus_rd(16'hFF02);
        check_eq("ovf_cleared", DIN_BUF, 16'h000A);

        // RX fill: A8 held off once full, then empty read flags overflow.
        RX_VALID = 1;
        for (int i = 0; i < 9; i++) begin
            RX_DATA = 8'hA0 + 8'(i);
            cycle();
        end
        check_eq("rx_full_ready", RX_READY, 1'b0);
        RX_VALID = 0;
        for (int i = 0; i < 8; i++) begin
            bus_rd(16'hFF04);
            check_eq("rx_data", DIN_BUF, 16'h00A0 + 16'(i));
        end
        bus_rd(16'hFF04);
        check_eq("rx_empty_read", DIN_BUF, 16'h0000);
        bus_rd(16'hFF02);
        check_eq("rx_ovf_status", DIN_BUF, 16'h001A);
        RX_VALID = 1; RX_DATA = 8'hA8;
        cycle();
        RX_VALID = 0;
        bus_rd(16'hFF04);
        check_eq("rx_late_byte", DIN_BUF, 16'h00A8);

        // Push and pop together on a full TX FIFO.
        for (int i = 0; i < 8; i++) bus_wr(16'hFF00, 16'h0010 + 16'(i), 1, 0);
        TX_READY = 1;
        bus_wr(16'hFF00, 16'h0018, 1, 0);
        TX_READY = 0;
        bus_rd(16'hFF02);
        check_eq("tx_full_pushpop", DIN_BUF, 16'h0809);
        TX_READY = 1;
        for (int i = 1; i <= 8; i++) begin
            check_eq("tx_pp_order", TX_DATA, 8'h10 + 8'(i));
            cycle();
        end
        TX_READY = 0;

        // Reset mid-operation: FIFOs flushed, RAM retained.
        bus_wr(16'h0400, 16'hBEEF, 1, 1);
        for (int i = 0; i < 5; i++) bus_wr(16'hFF00, 16'h0040 + 16'(i), 1, 0);
        bus_rd(16'h0400);
        check_eq("pre_rst_din", DIN_BUF, 16'hBEEF);
        RESET = 1'b1;
        #1;
        check_eq("mid_rst_din", DIN_BUF, 16'h0000);
        check_eq("mid_rst_tx_valid", TX_VALID, 1'b0);
        check_eq("mid_rst_rx_ready", RX_READY, 1'b1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        bus_rd(16'hFF02);
        check_eq("post_rst_status", DIN_BUF, 16'h000A);
        bus_rd(16'h0400);
        check_eq("ram_kept", DIN_BUF, 16'hBEEF);

        // Randomized traffic against the queue model, alternating fill and drain bias.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            bit          fill;
            fill = ((n / 400) % 2) == 0;
            a = 16'($urandom);
            if (fill && $urandom_range(0, 1) == 1) begin
                a = 16'hFF00;
            end else if ($urandom_range(0, 1) == 1) begin
                a[15:8] = 8'hFF;
                a[7:0]  = 8'(2 * $urandom_range(0, 3));
            end else begin
                a[12:1] = 12'($urandom_range(0, 15));
            end
            ADDR_BUF = a;
            DOUT_BUF = 16'($urandom);
            RD_BUF   = ($urandom_range(0, 2) == 0);
            WR0_BUF  = ($urandom_range(0, 2) == 0);
            WR1_BUF  = ($urandom_range(0, 2) == 0);
            TX_READY = fill ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            RX_VALID = ($urandom_range(0, 1) == 1);
            RX_DATA  = 8'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
